clkgen_m: RTL and testbench

CLKGEN_M -- requirements
Module: clkgen_m

---
 rtl/clkgen_pkg.sv | 23 ++
 rtl/phi0_track_m.sv | 60 ++++++
 rtl/clkgen_m.sv | 102 ++++++++++
 tb/tb_clkgen_m.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clkgen_pkg.sv
// Shared types and defaults for the CPU clock generator: FSM encoding and phase/lock tracker parameters.
package clkgen_pkg;

  localparam int unsigned PHASE_W          = 2;
  localparam int unsigned SYNC_STAGES_DEF  = 2;
  localparam int unsigned LOCK_TIMEOUT_DEF = 8;
  localparam logic [PHASE_W-1:0] PHASE_ALIGN_DEF = 2'd3;

  typedef enum logic [2:0] {
    ST_RST_HOLD   = 3'd0,
    ST_PHI1       = 3'd1,
    ST_FAST_PHI2  = 3'd2,
    ST_SLOW_WAIT  = 3'd3,
    ST_SLOW_PHI2A = 3'd4,
    ST_SLOW_PHI2B = 3'd5
  } state_e;

  // States in which the CPU phi2 clock is high.
  function automatic logic is_phi2(input state_e s);
    return (s == ST_FAST_PHI2) || (s == ST_SLOW_PHI2A) || (s == ST_SLOW_PHI2B);
  endfunction

endpackage

// File: rtl/phi0_track_m.sv
// Tracks the host phi0 clock: synchroniser, rising-edge detect, free-running phase count and lock/timeout.
module phi0_track_m
  import clkgen_pkg::*;
#(
  parameter int unsigned         SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter logic [PHASE_W-1:0]  PHASE_ALIGN  = PHASE_ALIGN_DEF,
  parameter int unsigned         LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic               bbc_ck8,
  input  logic               resetb,
  input  logic               bbc_ck2_phi0,
  output logic [PHASE_W-1:0] phase_q,
  output logic               locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CNT_W-1:0]       r_cnt;
  logic [PHASE_W-1:0]     r_phase;
  logic                   r_locked;

  logic                   w_edge;
  logic [CNT_W-1:0]       w_cnt_nxt;

  assign w_edge    = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

  // Edge realigns the phase and refreshes lock; otherwise count towards timeout.
  always_ff @(posedge bbc_ck8) begin
    if (!resetb) begin
      r_sync   <= '0;
      r_prev   <= 1'b0;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_locked <= 1'b0;
    end else begin
      r_sync <= SYNC_STAGES'({r_sync, bbc_ck2_phi0});
      r_prev <= r_sync[SYNC_STAGES-1];
      if (w_edge) begin
        r_phase  <= PHASE_ALIGN;
        r_cnt    <= '0;
        r_locked <= 1'b1;
      end else begin
        r_phase <= r_phase + PHASE_W'(1);
        if (r_cnt != CNT_W'(LOCK_TIMEOUT)) begin
          r_cnt <= w_cnt_nxt;
        end
        if (w_cnt_nxt == CNT_W'(LOCK_TIMEOUT)) begin
          r_locked <= 1'b0;
        end
      end
    end
  end

  assign phase_q = r_phase;
  assign locked  = r_locked;

endmodule

// File: rtl/clkgen_m.sv
// CPU clock generator: chooses 4 MHz fast cycles for on-board RAM or host-aligned slow cycles locked to phi0.
module clkgen_m
  import clkgen_pkg::*;
#(
  parameter int unsigned         SYNC_STAGES  = SYNC_STAGES_DEF,
  parameter logic [PHASE_W-1:0]  PHASE_ALIGN  = PHASE_ALIGN_DEF,
  parameter int unsigned         LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic bbc_ck8,
  input  logic resetb,
  input  logic bbc_ck2_phi0,
  input  logic accel_en,
  input  logic himem_sel,
  input  logic vpb,
  output logic cpu_ck_phi2,
  output logic cpu_ck_phi1,
  output logic bbc_cycle,
  output logic fast_cycle,
  output logic locked
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_phi2;
  logic               r_phi1;
  logic               r_bbc;
  logic               r_fast;
  logic               w_phi2_nxt;
  logic               w_bbc_nxt;
  logic               w_fast_nxt;
  logic               w_fast_req;
  logic               w_locked;
  logic [PHASE_W-1:0] w_phase_q;

  phi0_track_m #(
    .SYNC_STAGES  (SYNC_STAGES),
    .PHASE_ALIGN  (PHASE_ALIGN),
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_track (
    .bbc_ck8      (bbc_ck8),
    .resetb       (resetb),
    .bbc_ck2_phi0 (bbc_ck2_phi0),
    .phase_q      (w_phase_q),
    .locked       (w_locked)
  );

  assign w_fast_req = accel_en & himem_sel & vpb;

  // Next-state decode; the speed decision is only taken in PHI1 and phi2 states always run to completion.
  always_comb begin
    w_state_nxt = r_state;
    w_phi2_nxt  = 1'b0;
    w_bbc_nxt   = 1'b0;
    w_fast_nxt  = 1'b0;
    case (r_state)
      ST_RST_HOLD: begin
        if (w_locked) w_state_nxt = ST_PHI1;
      end
      ST_PHI1: begin
        if (!w_locked)                          w_state_nxt = ST_RST_HOLD;
        else if (w_fast_req)                    w_state_nxt = ST_FAST_PHI2;
        else if (w_phase_q == PHASE_W'(3))      w_state_nxt = ST_SLOW_PHI2A;
        else                                    w_state_nxt = ST_SLOW_WAIT;
      end
      ST_SLOW_WAIT: begin
        if (!w_locked)                          w_state_nxt = ST_RST_HOLD;
        else if (w_phase_q == PHASE_W'(3))      w_state_nxt = ST_SLOW_PHI2A;
      end
      ST_SLOW_PHI2A: w_state_nxt = ST_SLOW_PHI2B;
      ST_SLOW_PHI2B: w_state_nxt = ST_PHI1;
      ST_FAST_PHI2:  w_state_nxt = ST_PHI1;
      default:       w_state_nxt = ST_RST_HOLD;
    endcase
    w_phi2_nxt = is_phi2(w_state_nxt);
    w_bbc_nxt  = (w_state_nxt == ST_SLOW_PHI2A) || (w_state_nxt == ST_SLOW_PHI2B);
    w_fast_nxt = (w_state_nxt == ST_FAST_PHI2);
  end

  // State and clock outputs update together on the same edge.
  always_ff @(posedge bbc_ck8) begin
    if (!resetb) begin
      r_state <= ST_RST_HOLD;
      r_phi2  <= 1'b0;
      r_phi1  <= 1'b1;
      r_bbc   <= 1'b0;
      r_fast  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phi2  <= w_phi2_nxt;
      r_phi1  <= ~w_phi2_nxt;
      r_bbc   <= w_bbc_nxt;
      r_fast  <= w_fast_nxt;
    end
  end

  assign cpu_ck_phi2 = r_phi2;
  assign cpu_ck_phi1 = r_phi1;
  assign bbc_cycle   = r_bbc;
  assign fast_cycle  = r_fast;
  assign locked      = w_locked;

endmodule

// File: tb/tb_clkgen_m.sv
// Bench for clkgen_m: reset vector table, directed corner sequences and randomised phi0/select stimulus vs a cycle model.
module tb_clkgen_m;

  localparam int SYNC = 2;
  localparam int LT   = 8;
  localparam int PA   = 3;

  logic bbc_ck8 = 1'b0;
  logic resetb = 1'b0;
  logic bbc_ck2_phi0 = 1'b0;
  logic accel_en = 1'b0;
  logic himem_sel = 1'b0;
  logic vpb = 1'b1;
  logic cpu_ck_phi2, cpu_ck_phi1, bbc_cycle, fast_cycle, locked;
  logic [4:0] outs;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int per = 4;
  bit phi0_run = 0;

  clkgen_m dut (
    .bbc_ck8      (bbc_ck8),
    .resetb       (resetb),
    .bbc_ck2_phi0 (bbc_ck2_phi0),
    .accel_en     (accel_en),
    .himem_sel    (himem_sel),
    .vpb          (vpb),
    .cpu_ck_phi2  (cpu_ck_phi2),
    .cpu_ck_phi1  (cpu_ck_phi1),
    .bbc_cycle    (bbc_cycle),
    .fast_cycle   (fast_cycle),
    .locked       (locked)
  );

  assign outs = {cpu_ck_phi2, cpu_ck_phi1, bbc_cycle, fast_cycle, locked};

  always #5 bbc_ck8 = ~bbc_ck8;

  // Reference model: phi0 sample history, phase/lock rules, and phi2 as "high cycles remaining".
  bit h [SYNC+1];
  int m_phase = 0;
  bit m_locked = 0;
  int m_noedge = 0;
  bit m_hold = 1;
  int m_hi_rem = 0;
  bit m_first = 0;
  bit m_fast = 0;
  bit m_slow = 0;
  bit m_edge;
  int m_cur_phase;
  bit m_cur_locked;

  always @(posedge bbc_ck8) begin
    if (!resetb) begin
      for (int i = 0; i <= SYNC; i++) h[i] = 0;
      m_phase = 0; m_locked = 0; m_noedge = 0;
      m_hold = 1; m_hi_rem = 0; m_first = 0; m_fast = 0; m_slow = 0;
    end else begin
      m_edge       = h[SYNC-1] && !h[SYNC];
      m_cur_phase  = m_phase;
      m_cur_locked = m_locked;
      if (m_hi_rem > 1) begin
        m_hi_rem = m_hi_rem - 1;
      end else if (m_hi_rem == 1) begin
        m_hi_rem = 0; m_fast = 0; m_slow = 0; m_first = 1;
      end else if (m_hold) begin
        if (m_cur_locked) begin m_hold = 0; m_first = 1; end
      end else if (!m_cur_locked) begin
        m_hold = 1;
      end else if (m_first && accel_en && himem_sel && vpb) begin
        m_hi_rem = 1; m_fast = 1;
      end else if (m_cur_phase == 3) begin
        m_hi_rem = 2; m_slow = 1;
      end else begin
        m_first = 0;
      end
      if (m_edge) begin
        m_phase = PA; m_locked = 1; m_noedge = 0;
      end else begin
        m_phase = (m_phase + 1) % 4;
        if (m_noedge < LT) m_noedge = m_noedge + 1;
        if (m_noedge == LT) m_locked = 0;
      end
      for (int i = SYNC; i > 0; i--) h[i] = h[i-1];
      h[0] = bbc_ck2_phi0;
    end
  end

  function automatic logic [4:0] model_outs();
    return {m_hi_rem > 0, !(m_hi_rem > 0), m_slow, m_fast, m_locked};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input string name);
    @(posedge bbc_ck8);
    @(negedge bbc_ck8);
    check(name, {3'b0, outs}, {3'b0, model_outs()});
    check({name, "_phase"}, {6'b0, dut.w_phase_q}, 8'(m_phase));
    cyc++;
    bbc_ck2_phi0 = phi0_run ? ((cyc % per) < (per / 2)) : 1'b0;
  endtask

  typedef struct {
    logic       rstb;
    logic       p0;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs [9];
  logic pp;
  int hi_cnt;
  bit found;
  int r;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    // {phi2, phi1, bbc, fast, locked}
    vecs[0] = '{1'b0, 1'b0, 5'b01000};
    vecs[1] = '{1'b0, 1'b1, 5'b01000};
    vecs[2] = '{1'b0, 1'b0, 5'b01000};
    vecs[3] = '{1'b1, 1'b0, 5'b01000};
    vecs[4] = '{1'b1, 1'b1, 5'b01000};
    vecs[5] = '{1'b1, 1'b1, 5'b01000};
    vecs[6] = '{1'b1, 1'b0, 5'b01001};
    vecs[7] = '{1'b1, 1'b0, 5'b01001};
    vecs[8] = '{1'b1, 1'b0, 5'b01001};

    for (int i = 0; i < 9; i++) begin
      resetb = vecs[i].rstb;
      bbc_ck2_phi0 = vecs[i].p0;
      @(posedge bbc_ck8);
      @(negedge bbc_ck8);
      check($sformatf("vec%0d", i), {3'b0, outs}, {3'b0, vecs[i].exp});
    end

    // Slow-only host cycles
    phi0_run = 1; per = 4; accel_en = 0; himem_sel = 0; vpb = 1;
    hi_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      pp = cpu_ck_phi2;
      step("slow");
      if (i >= 8) begin
        if (cpu_ck_phi2 && !pp) check("slow_phase_at_rise", {6'b0, dut.w_phase_q}, 8'd0);
        check("slow_bbc_eq_phi2", {7'b0, bbc_cycle}, {7'b0, cpu_ck_phi2});
      end
      if (i >= 24) hi_cnt += int'(cpu_ck_phi2);
    end
    check("slow_duty", 8'(hi_cnt), 8'd8);

    // Fast cycles: phi2 toggles every clock
    accel_en = 1; himem_sel = 1; vpb = 1;
    for (int i = 0; i < 30; i++) begin
      pp = cpu_ck_phi2;
      step("fast");
      if (i >= 6) begin
        check("fast_toggle", {7'b0, cpu_ck_phi2}, {7'b0, ~pp});
        check("fast_no_bbc", {7'b0, bbc_cycle}, 8'd0);
        check("fast_flag", {7'b0, fast_cycle}, {7'b0, cpu_ck_phi2});
      end
    end

    // Fast-to-slow: drop himem_sel in PHI1 at phase 0
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!cpu_ck_phi2 && m_locked && !m_hold && m_phase == 0) found = 1;
      else step("f2s_seek");
    end
    check("f2s_found", {7'b0, found}, 8'd1);
    himem_sel = 0;
    for (int i = 0; i < 10 && !cpu_ck_phi2; i++) step("f2s_low");
    check("f2s_rise", {7'b0, cpu_ck_phi2}, 8'd1);
    check("f2s_rise_phase", {6'b0, dut.w_phase_q}, 8'd0);
    check("f2s_bbc_a", {7'b0, bbc_cycle}, 8'd1);
    step("f2s_hi2");
    check("f2s_hi2_phi2", {7'b0, cpu_ck_phi2}, 8'd1);
    step("f2s_end");
    check("f2s_end_phi2", {7'b0, cpu_ck_phi2}, 8'd0);

    // Clock loss: phi0 stops, lock drops, any phi2 finishes, then held low
    for (int i = 0; i < 8; i++) step("pre_loss");
    phi0_run = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step("loss");
      if (!locked) found = 1;
    end
    check("loss_seen", {7'b0, found}, 8'd1);
    for (int i = 0; i < 3; i++) step("loss_drain");
    for (int i = 0; i < 6; i++) begin
      step("loss_hold");
      check("loss_phi2_low", {7'b0, cpu_ck_phi2}, 8'd0);
    end

    phi0_run = 1; per = 4;
    for (int i = 0; i < 24; i++) step("relock");

    // Reset asserted while in SLOW_PHI2A
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      pp = bbc_cycle;
      step("pre_rst");
      if (bbc_cycle && !pp) found = 1;
    end
    check("rst_phi2a_found", {7'b0, found}, 8'd1);
    resetb = 0;
    step("rst_phi2");
    check("rst_in_phi2_outs", {3'b0, outs}, 8'b0000_1000);
    resetb = 1;

    // Randomised phi0 period/loss, selects and occasional reset
    for (int i = 0; i < 600; i++) begin
      if (i % 20 == 0) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) phi0_run = 0;
        else begin phi0_run = 1; per = int'($urandom_range(3, 9)); end
      end
      accel_en  = ($urandom_range(0, 3) != 0);
      himem_sel = ($urandom_range(0, 1) != 0);
      vpb       = ($urandom_range(0, 7) != 0);
      resetb    = ($urandom_range(0, 149) != 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
